// File: rtl/db_resp_pkg.sv
// db_resp_pkg -- shared types and constants for the db_responder slice.
//   state_e    : responder FSM states
//   DBC_HI     : MSB index of the command field
//   DBC_NORMAL : command code for a plain memory access
//   CNT_W      : width of the latency down-counter
package db_resp_pkg;

    localparam int DBC_HI = 1;
    localparam logic [DBC_HI:0] DBC_NORMAL = '0;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/db_resp_mem.sv
// db_resp_mem -- DEPTH x 32 word store with byte-lane writes and a registered read port.
//   clk        : clock
//   rd_en_i    : capture read word into rd_data_o on this edge
//   rd_addr_i  : read word index
//   wr_be_i    : byte-lane write enables (0 = no write)
//   wr_addr_i  : write word index
//   wr_data_i  : write data
//   rd_data_o  : registered read data
// Contents are deliberately not reset.
module db_resp_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [3:0]    wr_be_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i,
    output logic [31:0]   rd_data_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;
    logic [31:0] rd_word;

    // A read captured on the same edge that commits a write to the same word
    // must see the new bytes, so the write lanes are forwarded into the capture.
    always_comb begin
        rd_word = mem_q[rd_addr_i];
        for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b] && (wr_addr_i == rd_addr_i)) begin
                rd_word[8*b +: 8] = wr_data_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) begin
                mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
        end
        if (rd_en_i) begin
            rd_data_q <= rd_word;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/db_responder.sv
// db_responder -- single-outstanding request/response memory responder.
//   clk, rst_n         : clock, async active-low reset
//   db__en_3a          : request present (held until db__valid_4a)
//   db__addr_3a        : 30-bit word address
//   db__write_data_3a  : store data
//   db__write_en_3a    : byte-lane write enables, 0 = read
//   db__cmd_3a         : command, DBC_NORMAL = memory access, else maintenance
//   db__valid_4a       : one-cycle response strobe, LATENCY cycles after accept
//   db__data_4a        : read data (0 unless valid normal in-range read)
//   db__error_4a       : out-of-range normal access
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request held, counting down remaining latency
// RESP  | response presented; write commits at end; may accept next request
module db_responder
    import db_resp_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              db__en_3a,
    input  logic [29:0]       db__addr_3a,
    input  logic [31:0]       db__write_data_3a,
    input  logic [3:0]        db__write_en_3a,
    input  logic [DBC_HI:0]   db__cmd_3a,
    output logic              db__valid_4a,
    output logic [31:0]       db__data_4a,
    output logic              db__error_4a
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [29:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        we_q;
    logic [DBC_HI:0]   cmd_q;
    logic              valid_q;
    logic              error_q;

    logic              accept;
    logic              enter_resp;
    logic              in_range_new;
    logic              in_range_q;
    logic              err_new;
    logic [3:0]        mem_be;
    logic [AW-1:0]     mem_rd_addr;
    logic [31:0]       mem_rd_data;

    // Full 30-bit compare so high address bits never alias into the array.
    assign in_range_new = (db__addr_3a < DEPTH_W);
    assign in_range_q   = (addr_q < DEPTH_W);
    assign err_new      = (db__cmd_3a == DBC_NORMAL) && !in_range_new;

    assign accept     = db__en_3a && ((state_q == IDLE) || (state_q == RESP));
    assign enter_resp = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == '0));

    assign mem_be = ((state_q == RESP) && (cmd_q == DBC_NORMAL) && in_range_q) ? we_q : 4'h0;
    // With LATENCY=1 the read is captured on the accept edge, before addr_q holds it.
    assign mem_rd_addr = (state_q == WAIT) ? addr_q[AW-1:0] : db__addr_3a[AW-1:0];

    db_resp_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rd_en_i   (enter_resp),
        .rd_addr_i (mem_rd_addr),
        .wr_be_i   (mem_be),
        .wr_addr_i (addr_q[AW-1:0]),
        .wr_data_i (wdata_q),
        .rd_data_o (mem_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            cmd_q   <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (db__en_3a) begin
                        addr_q  <= db__addr_3a;
                        wdata_q <= db__write_data_3a;
                        we_q    <= db__write_en_3a;
                        cmd_q   <= db__cmd_3a;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                            error_q <= err_new;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                        error_q <= (cmd_q == DBC_NORMAL) && !in_range_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign db__valid_4a = valid_q;
    assign db__error_4a = error_q;
    assign db__data_4a  = (valid_q && (cmd_q == DBC_NORMAL) && in_range_q && (we_q == 4'h0))
                          ? mem_rd_data : 32'h0;

endmodule
